muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//  Multi-cycle sequencer for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//  Sits in EX beside the ALU; decode routes funct7=0000001 R-type ops here instead of the ALU.
//  Runs an iterative shift-add / restoring-divide datapath under an FSM.
//  Holds the pipeline via oBusy until it pulses oValid with the result.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  iClk       in   1     clock; single clock domain
//  iRst       in   1     synchronous, active-high reset
//  iValid     in   1     request strobe; accepted only in IDLE
//  iFunct3    in   3     000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//  iOperandA  in   XLEN  rs1 (multiplicand / dividend)
//  iOperandB  in   XLEN  rs2 (multiplier / divisor)
//  iFlush     in   1     abort any in-flight op
//  oBusy      out  1     high whenever state != IDLE; drives pipeline stall
//  oValid     out  1     one-cycle pulse; oResult valid this cycle only
//  oResult    out  XLEN  result; holds last value when oValid is low
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, oBusy=0, oValid=0, oResult=0; all internal regs cleared.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  - Fast path: IDLE -> DONE for div-by-zero or signed overflow.
//  Accept: in IDLE, iValid=1 samples the funct3 and operands (cycle 0).
//  - Signed operands are converted to magnitudes.
//  - Result sign is recorded:
//    - MUL/MULH: sign = A^B.
//    - MULHSU: sign = A only.
//    - DIV: sign = A^B.
//    - REM: sign = A.
//  CALC: one iteration per cycle, cycles 1..XLEN; counter runs 0..XLEN-1.
//  - MUL: 2*XLEN unsigned shift-add.
//  - DIV: restoring; one quotient bit per cycle; remainder in the partial register.
//  FIX: cycle XLEN+1; two's-complement negation of the product/quotient/remainder if the recorded sign=1.
//  DONE: cycle XLEN+2; oValid=1 and oResult is valid.
//  - Result select:
//    - MUL: low XLEN bits of the product.
//    - MULH*: high XLEN bits of the product.
//    - DIV*: quotient.
//    - REM*: remainder.
//  - Next state is IDLE, so back-to-back ops are spaced XLEN+3 cycles apart.
//  Latency: normal ops have oValid exactly XLEN+2 cycles after accept (34 for XLEN=32).
//  Special cases take the fast path, with oValid at cycle 1:
//  - B=0, DIV/DIVU: quotient = all ones.
//  - B=0, REM/REMU: remainder = A.
//  - Signed DIV with A=min_int, B=-1: quotient = min_int.
//  - Signed REM with A=min_int, B=-1: remainder = 0.
//  oBusy=1 from cycle 1 through DONE inclusive; oBusy=0 in the accept cycle.
//  iValid while oBusy=1 is ignored; no queuing, and the upstream stall guarantees no loss.
//  iFlush=1 in any state:
//  - next state IDLE, counter=0, oValid=0 next cycle, oResult unchanged.
//  - iFlush wins over a simultaneous iValid in IDLE (request dropped).
//  iRst mid-operation: next cycle is the reset state; no oValid pulse; iRst overrides iFlush and iValid.
//  All arithmetic is modulo 2^XLEN (product 2^(2*XLEN)); no overflow flags.
// TESTING
//  MUL A=7, B=0xFFFFFFFD:
//  - oValid at cycle 34, oResult=0xFFFFFFEB.
//  - oBusy high cycles 1..34.
//  MULHU A=B=0xFFFFFFFF -> oResult=0xFFFFFFFE.
//  MULH A=B=0x80000000 -> oResult=0x40000000.
//  MULHSU A=0xFFFFFFFF, B=2 -> oResult=0xFFFFFFFF.
//  DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD.
//  REM same operands -> 0xFFFFFFFF.
//  DIVU A=7, B=2 -> 3.
//  DIVU A=5, B=0 -> 0xFFFFFFFF at cycle 1.
//  REMU A=5, B=0 -> 5 at cycle 1.
//  DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000 at cycle 1.
//  REM same operands -> 0.
//  Second iValid at cycle 10 of a MUL:
//  - ignored; exactly one oValid, at cycle 34.
//  - a new op accepted at cycle 35 completes at cycle 69.
//  iFlush at cycle 15:
//  - IDLE at cycle 16, no oValid.
//  iRst at cycle 20:
//  - all outputs 0 next cycle, no oValid.
//  - a fresh op then completes normally.

Source files
------------

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle RV32M multiply/divide sequencer
// Shift-add multiply and restoring divide on magnitudes, sign fix-up applied afterwards.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iValid,
  input  logic [2:0]      iFunct3,
  input  logic [XLEN-1:0] iOperandA,
  input  logic [XLEN-1:0] iOperandB,
  input  logic            iFlush,
  output logic            oBusy,
  output logic            oValid,
  output logic [XLEN-1:0] oResult
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              sign_q, sign_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic              a_sgn, b_sgn, is_div, div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_trial, div_diff;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign a_sgn    = iOperandA[XLEN-1] & (iFunct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
  assign b_sgn    = iOperandB[XLEN-1] & (iFunct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
  assign a_mag    = a_sgn ? -iOperandA : iOperandA;
  assign b_mag    = b_sgn ? -iOperandB : iOperandB;
  assign is_div   = iFunct3[2];
  assign div_zero = is_div && (iOperandB == '0);
  assign div_ovf  = is_div && !iFunct3[0] && (iOperandA == MIN_INT) && (iOperandB == '1);

  // Multiply: accumulate into the high half, multiplier shifts out of the low half.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: partial remainder in the high half, dividend shifts in / quotient shifts into the low half.
  assign div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_trial - {1'b0, opnd_q};
  assign div_rem   = div_diff[XLEN] ? div_trial[XLEN-1:0] : div_diff[XLEN-1:0];

  assign prod_fix = sign_q ? -acc_q : acc_q;
  assign quo_fix  = sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = sign_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_d   = sign_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (iValid) begin
          op_d  = iFunct3;
          cnt_d = '0;
          if (div_zero) begin
            result_d = iFunct3[1] ? iOperandA : '1;
            state_d  = DONE;
          end else if (div_ovf) begin
            result_d = iFunct3[1] ? '0 : MIN_INT;
            state_d  = DONE;
          end else begin
            opnd_d = is_div ? b_mag : a_mag;
            acc_d  = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            sign_d = (is_div && iFunct3[1]) || (iFunct3 == 3'b010) ? a_sgn : (a_sgn ^ b_sgn);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (op_q[2]) acc_d = {div_rem, acc_q[XLEN-2:0], ~div_diff[XLEN]};
        else         acc_d = {mul_sum, acc_q[XLEN-1:1]};
        if (cnt_q == CW'(XLEN-1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        case (op_q)
          3'b000:                 result_d = prod_fix[XLEN-1:0];
          3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
          3'b100, 3'b101:         result_d = quo_fix;
          default:                result_d = rem_fix;
        endcase
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Flush drops any request and leaves the visible result untouched.
    if (iFlush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign oBusy   = (state_q != IDLE);
  assign oValid  = (state_q == DONE);
  assign oResult = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq
// Driver pushes model results with expected completion cycle; a negedge monitor pops and compares.
module tb_muldiv_seq;

  logic        iClk = 1'b0;
  logic        iRst, iValid, iFlush;
  logic [2:0]  iFunct3;
  logic [31:0] iOperandA, iOperandB;
  logic        oBusy, oValid;
  logic [31:0] oResult;

  muldiv_seq #(.XLEN(32)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .iFunct3(iFunct3),
    .iOperandA(iOperandA), .iOperandB(iOperandB), .iFlush(iFlush),
    .oBusy(oBusy), .oValid(oValid), .oResult(oResult)
  );

  always #5 iClk = ~iClk;

  typedef struct { logic [31:0] res; int cyc; } exp_t;
  exp_t        scb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_last = '0;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sbv, ua, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = sa * sbv; return p[31:0];  end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sbv; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sbv; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  // Monitor: every oValid must match the oldest outstanding expectation, result and cycle.
  always @(negedge iClk) begin
    if (oValid === 1'b1) begin
      if (scb.size() == 0) begin
        check("unexpected_valid", 64'(oResult), 64'hDEAD_0000_0000_0000);
      end else begin
        exp_t e;
        e = scb.pop_front();
        check("result", 64'(oResult), 64'(e.res));
        check("valid_cycle", 64'(cyc), 64'(e.cyc));
        model_last = e.res;
      end
    end
  end

  // Called at posedge+1 with the DUT idle; holds iValid for exactly one cycle.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit expect_it);
    exp_t e;
    iValid = 1'b1; iFunct3 = f3; iOperandA = a; iOperandB = b;
    if (expect_it) begin
      e.res = ref_model(f3, a, b);
      e.cyc = cyc + latency(f3, a, b);
      scb.push_back(e);
    end
    @(posedge iClk); #1;
    iValid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (oBusy === 1'b1 && n < 200) begin
      @(posedge iClk); #1;
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'(n), 64'(0));
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit chk_busy);
    int n;
    issue(f3, a, b, 1'b1);
    wait_idle(n);
    if (chk_busy) check("busy_cycles", 64'(n), 64'(latency(f3, a, b)));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n, c0;
    iRst = 1'b1; iValid = 1'b0; iFlush = 1'b0; iFunct3 = '0; iOperandA = '0; iOperandB = '0;
    repeat (3) @(posedge iClk);
    #1;
    check("rst_busy", 64'(oBusy), 64'(0));
    check("rst_valid", 64'(oValid), 64'(0));
    check("rst_result", 64'(oResult), 64'(0));
    iRst = 1'b0;
    @(posedge iClk); #1;

    // Directed corner cases
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd5, 32'd7, 32'd2, 1'b0);
    run_op(3'd5, 32'd5, 32'd0, 1'b1);
    run_op(3'd7, 32'd5, 32'd0, 1'b1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Second request mid-operation is ignored; next op accepted at cycle 35
    c0 = cyc;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    repeat (9) begin @(posedge iClk); #1; end
    iValid = 1'b1; iFunct3 = 3'd5; iOperandA = 32'd9; iOperandB = 32'd0;
    @(posedge iClk); #1;
    iValid = 1'b0;
    wait_idle(n);
    check("reaccept_cycle", 64'(cyc - c0), 64'(35));
    run_op(3'd5, 32'd100, 32'd7, 1'b1);

    // Flush at cycle 15
    issue(3'd4, 32'd1000, 32'd3, 1'b0);
    repeat (14) begin @(posedge iClk); #1; end
    iFlush = 1'b1;
    @(posedge iClk); #1;
    iFlush = 1'b0;
    check("flush_busy", 64'(oBusy), 64'(0));
    check("flush_result", 64'(oResult), 64'(model_last));
    repeat (40) begin @(posedge iClk); #1; end

    // Flush beats a simultaneous request in IDLE
    iFlush = 1'b1;
    issue(3'd7, 32'd5, 32'd0, 1'b0);
    iFlush = 1'b0;
    check("flush_drop_busy", 64'(oBusy), 64'(0));
    repeat (3) begin @(posedge iClk); #1; end

    // Reset at cycle 20
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (19) begin @(posedge iClk); #1; end
    iRst = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0;
    check("midrst_busy", 64'(oBusy), 64'(0));
    check("midrst_valid", 64'(oValid), 64'(0));
    check("midrst_result", 64'(oResult), 64'(0));
    model_last = '0;
    repeat (40) begin @(posedge iClk); #1; end
    run_op(3'd0, 32'd6, 32'd7, 1'b1);

    // Randomized ops
    for (int i = 0; i < 60; i++) begin
      logic [2:0] f3;
      f3 = 3'($urandom_range(0, 7));
      run_op(f3, pick(), pick(), 1'b1);
    end

    repeat (3) begin @(posedge iClk); #1; end
    check("scoreboard_empty", 64'(scb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
